// File: rtl/l1_dcache_ctrl.sv
// l1_dcache_ctrl: direct-mapped, write-through, no-write-allocate L1 data cache controller
// with word-by-word refill and coherence snoop invalidation.
module l1_dcache_ctrl #(
  parameter int n     = 32,
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         core_req,
  input  logic         core_we,
  input  logic [n-1:0] core_addr,
  input  logic [n-1:0] core_wdata,
  output logic [n-1:0] core_rdata,
  output logic         L1_busy,
  output logic         mem_req,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata,
  input  logic         mem_ack,
  input  logic         snoop_inv,
  input  logic [n-1:0] snoop_addr
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = n - IW - OW - 2;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE_THRU} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [n-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic kill_q, kill_d;
  logic [TW-1:0] tag_arr [LINES];
  logic [n-1:0] data_arr [LINES][WORDS];
  logic [TW-1:0] c_tag, s_tag, q_tag;
  logic [IW-1:0] c_idx, s_idx, q_idx;
  logic [OW-1:0] c_off, q_off, wr_off;
  logic hit, s_hit, s_line, wr_en, tag_we;
  logic [n-1:0] wr_data;
  logic unused_ok;
  assign {c_tag, c_idx, c_off} = core_addr[n-1:2];
  assign {s_tag, s_idx} = snoop_addr[n-1:OW+2];
  assign {q_tag, q_idx, q_off} = addr_q[n-1:2];
  assign unused_ok = ^{core_addr[1:0], snoop_addr[OW+1:0]};
  assign hit = core_req & valid_q[c_idx] & (tag_arr[c_idx] == c_tag);
  assign s_hit = snoop_inv & valid_q[s_idx] & (tag_arr[s_idx] == s_tag);
  // a snoop on the line being refilled must suppress the valid bit it would set
  assign s_line = snoop_inv & (snoop_addr[n-1:OW+2] == addr_q[n-1:OW+2]);
  always_comb begin
    L1_busy = reset ? core_req & core_we : (state_q != IDLE) | (core_req & (core_we | ~hit));
    core_rdata = (state_q == IDLE && hit && !core_we) ? data_arr[c_idx][c_off] : '0;
    mem_req = state_q != IDLE;
    mem_we = state_q == WRITE_THRU;
    mem_addr = state_q == REFILL ? {addr_q[n-1:OW+2], cnt_q, 2'b00} :
               state_q == WRITE_THRU ? addr_q : '0;
    mem_wdata = state_q == WRITE_THRU ? wdata_q : '0;
  end
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    kill_d = kill_q;
    wr_en = 1'b0;
    tag_we = 1'b0;
    wr_off = state_q == REFILL ? cnt_q : q_off;
    wr_data = state_q == REFILL ? mem_rdata : wdata_q;
    if (s_hit) valid_d[s_idx] = 1'b0;
    case (state_q)
      IDLE: if (core_req & (core_we | ~hit)) begin
        state_d = core_we ? WRITE_THRU : REFILL;
        addr_d = {core_addr[n-1:2], 2'b00};
        wdata_d = core_wdata;
        cnt_d = '0;
        kill_d = snoop_inv & (snoop_addr[n-1:OW+2] == core_addr[n-1:OW+2]);
        if (!core_we) valid_d[c_idx] = 1'b0;
      end
      REFILL: begin
        if (s_line) kill_d = 1'b1;
        if (mem_ack) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            tag_we = 1'b1;
            valid_d[q_idx] = ~(kill_q | s_line);
            state_d = IDLE;
          end
        end
      end
      WRITE_THRU: if (mem_ack) begin
        wr_en = valid_q[q_idx] & (tag_arr[q_idx] == q_tag);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      kill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      kill_q <= kill_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) data_arr[q_idx][wr_off] <= wr_data;
    if (tag_we) tag_arr[q_idx] <= q_tag;
  end
endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// tb_l1_dcache_ctrl: directed and randomized checks of the L1 cache controller against
// a memory-plus-line-state reference model (loads must always return current memory contents).
module tb_l1_dcache_ctrl;
  logic clk = 1'b0, reset = 1'b1, core_req = 1'b0, core_we = 1'b0, mem_ack = 1'b0, snoop_inv = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0, mem_rdata = '0, snoop_addr = '0;
  logic [31:0] core_rdata, mem_addr, mem_wdata;
  logic L1_busy, mem_req, mem_we;
  int checks = 0, failures = 0;
  logic [31:0] mm [logic [31:0]];
  bit mvalid [16];
  logic [31:0] mtag [16];

  always #5 clk = ~clk;

  l1_dcache_ctrl #(.n(32), .LINES(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .L1_busy(L1_busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 16) % 16);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[line_of(a)] && (mtag[line_of(a)] == a / 256);
  endfunction

  task automatic model_snoop(input logic [31:0] a);
    if (model_hit(a)) mvalid[line_of(a)] = 1'b0;
  endtask

  task automatic do_snoop(input logic [31:0] a, input bit change);
    if (change) mm[a] = $urandom;
    snoop_inv = 1'b1;
    snoop_addr = a;
    @(posedge clk); #1;
    snoop_inv = 1'b0;
    model_snoop(a);
  endtask

  task automatic do_load(input logic [31:0] a, input bit snoop_mid, input string nm);
    int li = line_of(a);
    bit exp_hit = model_hit(a);
    int refills = 0;
    int exp_refills = exp_hit ? 0 : (snoop_mid ? 2 : 1);
    logic [31:0] base = a & ~32'hF;
    core_req = 1'b1; core_we = 1'b0; core_addr = a; #1;
    checks++;
    if (L1_busy !== !exp_hit || (exp_hit && mem_req !== 1'b0)) begin
      failures++;
      $display("FAIL %s first_cycle: busy=%b mem_req=%b, required busy=%b", nm, L1_busy, mem_req, !exp_hit);
    end
    while (L1_busy === 1'b1 && refills < 3) begin
      @(posedge clk); #1;
      mvalid[li] = 1'b0;
      for (int b = 0; b < 4; b++) begin
        int d;
        d = $urandom_range(0, 2);
        for (int w = 0; w <= d; w++) begin
          checks++;
          if ({mem_req, mem_we, L1_busy, mem_addr} !== {3'b101, base + 32'(4 * b)}) begin
            failures++;
            $display("FAIL %s refill_beat%0d: req=%b we=%b busy=%b addr=%h, required 1 0 1 %h",
                     nm, b, mem_req, mem_we, L1_busy, mem_addr, base + 32'(4 * b));
          end
          if (w == d) begin mem_ack = 1'b1; mem_rdata = memval(base + 32'(4 * b)); end
          if (snoop_mid && refills == 0 && b == 1 && w == 0) begin snoop_inv = 1'b1; snoop_addr = a; end
          @(posedge clk); #1;
          mem_ack = 1'b0; snoop_inv = 1'b0; mem_rdata = $urandom;
        end
      end
      refills++;
      mtag[li] = a / 256;
      mvalid[li] = !(snoop_mid && refills == 1);
      #1;
    end
    checks++;
    if (refills != exp_refills) begin
      failures++;
      $display("FAIL %s refill_count: got %0d, required %0d", nm, refills, exp_refills);
    end
    checks++;
    if (L1_busy !== 1'b0 || core_rdata !== memval(a)) begin
      failures++;
      $display("FAIL %s load_data: busy=%b rdata=%h, required busy=0 rdata=%h", nm, L1_busy, core_rdata, memval(a));
    end
    @(posedge clk); #1;
    core_req = 1'b0; #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] dat, input bit snoop_same, input string nm);
    int k = $urandom_range(0, 2);
    core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = dat; #1;
    checks++;
    if (L1_busy !== 1'b1 || core_rdata !== 32'h0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s store_accept: busy=%b rdata=%h mem_req=%b, required 1 0 0", nm, L1_busy, core_rdata, mem_req);
    end
    @(posedge clk); #1;
    for (int w = 0; w <= k; w++) begin
      checks++;
      if ({mem_req, mem_we, L1_busy, mem_addr, mem_wdata} !== {3'b111, a, dat}) begin
        failures++;
        $display("FAIL %s write_thru: req=%b we=%b busy=%b addr=%h wdata=%h, required 1 1 1 %h %h",
                 nm, mem_req, mem_we, L1_busy, mem_addr, mem_wdata, a, dat);
      end
      if (w == k) begin
        mem_ack = 1'b1;
        if (snoop_same) begin snoop_inv = 1'b1; snoop_addr = a; end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; snoop_inv = 1'b0;
    end
    core_req = 1'b0; core_we = 1'b0; #1;
    mm[a] = dat;
    if (snoop_same) model_snoop(a);
    checks++;
    if (L1_busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s store_done: busy=%b mem_req=%b, required 0 0", nm, L1_busy, mem_req);
    end
  endtask

  task automatic test_reset;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; #2;
    checks++;
    if ({L1_busy, mem_req, mem_we} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || core_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_load_outputs: busy=%b req=%b we=%b addr=%h wdata=%h rdata=%h, required all 0",
               L1_busy, mem_req, mem_we, mem_addr, mem_wdata, core_rdata);
    end
    core_we = 1'b1; #1;
    checks++;
    if (L1_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_store_busy: busy=%b, required 1", L1_busy);
    end
    core_req = 1'b0; core_we = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (L1_busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%b mem_req=%b, required 0 0", L1_busy, mem_req);
    end
  endtask

  task automatic test_cold_load;
    do_load(32'h100, 1'b0, "cold_load_0x100");
  endtask

  task automatic test_load_hit;
    do_load(32'h108, 1'b0, "hit_load_0x108");
  endtask

  task automatic test_store_hit;
    do_store(32'h104, 32'hDEAD_BEEF, 1'b0, "store_hit_0x104");
    do_load(32'h104, 1'b0, "load_after_store_0x104");
  endtask

  task automatic test_store_miss;
    do_store(32'h2000, $urandom, 1'b0, "store_miss_0x2000");
    do_load(32'h2000, 1'b0, "load_after_store_miss_0x2000");
  endtask

  task automatic test_snoop;
    do_snoop(32'h100, 1'b1);
    do_load(32'h100, 1'b1, "snoop_during_refill_0x100");
    do_snoop(32'h1100, 1'b0);
    do_load(32'h100, 1'b0, "hit_after_foreign_snoop");
  endtask

  task automatic test_snoop_store_race;
    do_store(32'h104, $urandom, 1'b1, "store_hit_with_snoop");
    do_load(32'h104, 1'b0, "load_after_snoop_race");
  endtask

  task automatic test_idle_ack;
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b0 || L1_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack: mem_req=%b busy=%b, required 0 0", mem_req, L1_busy);
    end
    do_load(32'h104, 1'b0, "hit_after_idle_ack");
  endtask

  task automatic test_reset_mid_refill;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h3040;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3040) begin
      failures++;
      $display("FAIL mid_refill_start: req=%b addr=%h, required 1 00003040", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0; #2;
    reset = 1'b1; #1;
    checks++;
    if ({mem_req, mem_we, L1_busy} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_outputs: req=%b we=%b busy=%b addr=%h wdata=%h, required all 0",
               mem_req, mem_we, L1_busy, mem_addr, mem_wdata);
    end
    core_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    @(posedge clk); #1;
    do_load(32'h100, 1'b0, "load_after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      int op;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
      op = $urandom_range(0, 9);
      if (op < 5) do_load(a, 1'b0, "rnd_load");
      else if (op < 8) do_store(a, $urandom, 1'b0, "rnd_store");
      else do_snoop(a, op == 8);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_load();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_snoop();
    test_snoop_store_race();
    test_idle_ack();
    test_reset_mid_refill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
